// File: rtl/vs_sci_writer.sv
// vs_sci_writer: turns vol/CURRENT changes into VS1003 SCI write frames (SCI_VOL / SCI_MODE soft reset).
module vs_sci_writer #(
    parameter int          CLK_DIV   = 4,
    parameter logic [7:0]  VOL_ADDR  = 8'h0B,
    parameter logic [7:0]  MODE_ADDR = 8'h00,
    parameter logic [15:0] MODE_SRST = 16'h0804
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] vol,
    input  logic [2:0]  CURRENT,
    input  logic        DREQ,
    output logic        XCS,
    output logic        SCLK,
    output logic        MOSI,
    output logic        busy,
    output logic        track_start,
    output logic [2:0]  track_id
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, WAIT_DREQ, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   shreg, frame;
    logic [15:0]   vol_last;
    logic [2:0]    cur_last;
    logic [1:0]    dreq_q;
    logic          vol_pend, trk_pend, is_mode, tick, launch, pend;
    assign tick   = cnt == CW'(CLK_DIV - 1);
    assign pend   = vol_pend | trk_pend;
    assign launch = state == WAIT_DREQ && dreq_q[1];
    assign frame  = trk_pend ? {8'h02, MODE_ADDR, MODE_SRST} : {8'h02, VOL_ADDR, vol};
    assign busy   = state != IDLE;
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end
    // After a MODE frame volume must be re-applied, so GAP goes straight back to WAIT_DREQ
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = pend ? WAIT_DREQ : IDLE;
            WAIT_DREQ: state_n = dreq_q[1] ? SETUP : WAIT_DREQ;
            SETUP:     state_n = tick ? SHIFT : SETUP;
            SHIFT:     state_n = (tick && SCLK && bit_cnt == 5'd31) ? HOLD : SHIFT;
            HOLD:      state_n = tick ? GAP : HOLD;
            GAP:       state_n = tick ? ((pend || is_mode) ? WAIT_DREQ : IDLE) : GAP;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            dreq_q      <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            vol_last    <= '0;
            cur_last    <= '0;
            vol_pend    <= 1'b1;
            trk_pend    <= 1'b0;
            is_mode     <= 1'b0;
            XCS         <= 1'b1;
            SCLK        <= 1'b0;
            MOSI        <= 1'b0;
            track_start <= 1'b0;
            track_id    <= '0;
        end else begin
            dreq_q      <= {dreq_q[0], DREQ};
            cnt         <= (tick || state_n != state) ? '0 : cnt + 1'b1;
            track_start <= 1'b0;
            if (vol != vol_last) vol_pend <= 1'b1;
            if (CURRENT != cur_last) trk_pend <= 1'b1;
            if (launch) begin
                shreg   <= frame;
                MOSI    <= frame[31];
                XCS     <= 1'b0;
                SCLK    <= 1'b0;
                bit_cnt <= '0;
                is_mode <= trk_pend;
                if (trk_pend) begin
                    cur_last <= CURRENT;
                    trk_pend <= 1'b0;
                end else begin
                    vol_last <= vol;
                    vol_pend <= 1'b0;
                end
            end
            // Data moves only on the falling SCLK edge (SPI mode 0)
            if (state == SHIFT && tick) begin
                SCLK <= !SCLK;
                if (SCLK) begin
                    shreg   <= shreg << 1;
                    MOSI    <= shreg[30];
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == HOLD && tick) XCS <= 1'b1;
            if (state == GAP && tick && is_mode) begin
                track_start <= 1'b1;
                track_id    <= cur_last;
                vol_pend    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vs_sci_writer.sv
// tb_vs_sci_writer: directed checks of SCI frame content, timing, priority and reset for vs_sci_writer.
module tb_vs_sci_writer;
    logic        CLK = 1'b0, RST = 1'b1, DREQ = 1'b1;
    logic [15:0] vol = 16'h4040;
    logic [2:0]  CURRENT = 3'd0;
    logic        XCS, SCLK, MOSI, busy, track_start;
    logic [2:0]  track_id;
    int nvec = 0, nerr = 0, cyc = 0, ts_cnt = 0, ts_cyc = 0;
    logic [2:0] ts_id = '0;

    vs_sci_writer dut (
        .CLK(CLK), .RST(RST), .vol(vol), .CURRENT(CURRENT), .DREQ(DREQ),
        .XCS(XCS), .SCLK(SCLK), .MOSI(MOSI), .busy(busy),
        .track_start(track_start), .track_id(track_id)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) if (track_start === 1'b1) begin
        ts_cnt++;
        ts_cyc = cyc;
        ts_id  = track_id;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for XCS to fall, then collects MOSI on each SCLK rise until XCS rises.
    task automatic get_frame(output logic [31:0] w, output int len, output int t_fall);
        logic ps;
        w = '0; len = 0; t_fall = -1;
        for (int i = 0; i < 2000 && XCS !== 1'b0; i++) @(negedge CLK);
        if (XCS !== 1'b0) return;
        t_fall = cyc;
        ps = SCLK;
        while (XCS === 1'b0 && len < 1000) begin
            if (SCLK === 1'b1 && ps !== 1'b1) w = {w[30:0], MOSI};
            ps = SCLK;
            len++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [31:0] w;
        int len, f1, f2, k, lows;
        repeat (3) @(negedge CLK);
        chk("rst_xcs", 32'(XCS), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ts", 32'(track_start), 32'd0);
        chk("rst_tid", 32'(track_id), 32'd0);

        RST = 1'b0;
        get_frame(w, len, f1);
        chk("t1_word", w, 32'h020B4040);
        chk("t1_len", 32'(len), 32'd264);
        chk("t1_nots", 32'(ts_cnt), 32'd0);
        repeat (20) @(negedge CLK);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_xcs", 32'(XCS), 32'd1);

        vol = 16'h5050;
        get_frame(w, len, f1);
        chk("t2_word", w, 32'h020B5050);
        chk("t2_len", 32'(len), 32'd264);
        repeat (20) @(negedge CLK);

        DREQ = 1'b0;
        vol = 16'h7070;
        repeat (20) @(negedge CLK);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_xcs_hold", 32'(XCS), 32'd1);
        DREQ = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (XCS !== 1'b0 && k < 20);
        chk("t3_latency", 32'(k), 32'd3);
        get_frame(w, len, f1);
        chk("t3_word", w, 32'h020B7070);
        chk("t3_len", 32'(len), 32'd264);

        repeat (10) @(negedge CLK);
        vol = 16'h4040;
        for (int i = 0; i < 100 && XCS !== 1'b0; i++) @(negedge CLK);
        repeat (50) @(negedge CLK);
        vol = 16'h5050;
        repeat (50) @(negedge CLK);
        vol = 16'h6060;
        for (int i = 0; i < 400 && XCS !== 1'b1; i++) @(negedge CLK);
        get_frame(w, len, f1);
        chk("t4_word", w, 32'h020B6060);
        lows = 0;
        repeat (600) begin
            @(negedge CLK);
            if (XCS === 1'b0) lows++;
        end
        chk("t4_no_extra", 32'(lows), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        CURRENT = 3'd3;
        vol = 16'h3030;
        get_frame(w, len, f1);
        chk("t5_mode_word", w, 32'h02000804);
        chk("t5_mode_len", 32'(len), 32'd264);
        get_frame(w, len, f2);
        chk("t5_vol_word", w, 32'h020B3030);
        chk("t5_spacing", 32'(f2 - f1), 32'd269);
        chk("t5_ts_cnt", 32'(ts_cnt), 32'd1);
        chk("t5_ts_id", 32'(ts_id), 32'd3);
        chk("t5_ts_time", 32'(ts_cyc - f1), 32'd268);
        chk("t5_track_id", 32'(track_id), 32'd3);
        repeat (20) @(negedge CLK);

        vol = 16'h1111;
        for (int i = 0; i < 100 && XCS !== 1'b0; i++) @(negedge CLK);
        repeat (40) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("t6_xcs", 32'(XCS), 32'd1);
        chk("t6_sclk", 32'(SCLK), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tid", 32'(track_id), 32'd0);
        RST = 1'b0;
        get_frame(w, len, f1);
        chk("t6_mode_word", w, 32'h02000804);
        get_frame(w, len, f2);
        chk("t6_vol_word", w, 32'h020B1111);
        chk("t6_vol_len", 32'(len), 32'd264);
        chk("t6_ts_cnt", 32'(ts_cnt), 32'd2);
        chk("t6_ts_id", 32'(ts_id), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
